// File: rtl/cordic_stage_serial_if.sv
// rtl/cordic_stage_serial_if.sv - digit-serial CORDIC word stream (start/vld/mode/tag + X/Y/A digits)
interface cordic_stage_serial_if #(
   parameter int DGW = 2,
   parameter int TW  = 1
);
   logic           start;
   logic           vld;
   logic           mode;
   logic [TW-1:0]  tag;
   logic [DGW-1:0] x;
   logic [DGW-1:0] y;
   logic [DGW-1:0] a;

   // A downstream stage keys purely on start, so vld is not part of the sink view.
   modport master (output start, vld, mode, tag, x, y, a);
   modport slave  (input  start, mode, tag, x, y, a);
endinterface

// File: rtl/cordic_stage_serial.sv
// rtl/cordic_stage_serial.sv - digit-serial CORDIC micro-rotation stage, double-buffered in/out shift registers
// Define CORDIC_SAT_EN to saturate X'/Y'/A' on signed overflow instead of wrapping.
module cordic_stage_serial #(
   parameter int DW    = 12,
   parameter int DGW   = 2,
   parameter int STAGE = 1,
   parameter int ATAN  = 301,
   parameter int TW    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cordic_stage_serial_if.slave  up,
   cordic_stage_serial_if.master dn,
   output logic                  protocol_err
);
   localparam int NDIG = DW / DGW;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
`ifdef CORDIC_SAT_EN
   localparam int EW = DW + 1;
`else
   localparam int EW = DW;
`endif
   localparam logic [DW-1:0] ATAN_W = ATAN[DW-1:0];

   logic          in_busy;
   logic [CW-1:0] in_cnt;
   logic [DW-1:0] x_sr, y_sr, a_sr;
   logic          in_mode_r;
   logic [TW-1:0] in_tag_r;

   logic [DW-1:0] x_w, y_w, a_w;
   logic          w_last;

   logic          out_busy;
   logic [CW-1:0] out_cnt;
   logic [DW-1:0] x_osr, y_osr, a_osr;
   logic          out_mode_r;
   logic [TW-1:0] out_tag_r;

   logic                 d_pos;
   logic signed [DW-1:0] x_sh, y_sh;
   logic signed [EW-1:0] x_e, y_e, a_e, xs_e, ys_e, atan_e;
   logic signed [EW-1:0] x_sum, y_sum, a_sum;
   logic [DW-1:0]        x_res, y_res, a_res;

   function automatic logic [DW-1:0] fit(input logic [EW-1:0] v);
`ifdef CORDIC_SAT_EN
      if (v[EW-1] != v[EW-2])
         fit = v[EW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
         fit = v[DW-1:0];
`else
      fit = v;
`endif
   endfunction

   // Assembled word: the digit on the bus this cycle completes the shift register.
   assign x_w    = {up.x, x_sr[DW-1:DGW]};
   assign y_w    = {up.y, y_sr[DW-1:DGW]};
   assign a_w    = {up.a, a_sr[DW-1:DGW]};
   assign w_last = in_busy && (in_cnt == LAST) && !up.start;

   always_comb begin
      d_pos  = in_mode_r ? y_w[DW-1] : ~a_w[DW-1];
      x_sh   = $signed(x_w) >>> STAGE;
      y_sh   = $signed(y_w) >>> STAGE;
      x_e    = EW'($signed(x_w));
      y_e    = EW'($signed(y_w));
      a_e    = EW'($signed(a_w));
      xs_e   = EW'(x_sh);
      ys_e   = EW'(y_sh);
      atan_e = EW'($signed(ATAN_W));
      if (d_pos) begin
         x_sum = x_e - ys_e;
         y_sum = y_e + xs_e;
         a_sum = a_e - atan_e;
      end else begin
         x_sum = x_e + ys_e;
         y_sum = y_e - xs_e;
         a_sum = a_e + atan_e;
      end
      x_res = fit(x_sum);
      y_res = fit(y_sum);
      a_res = fit(a_sum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_busy      <= 1'b0;
         in_cnt       <= '0;
         x_sr         <= '0;
         y_sr         <= '0;
         a_sr         <= '0;
         in_mode_r    <= 1'b0;
         in_tag_r     <= '0;
         protocol_err <= 1'b0;
      end else begin
         protocol_err <= up.start && in_busy;
         if (up.start || in_busy) begin
            x_sr <= x_w;
            y_sr <= y_w;
            a_sr <= a_w;
         end
         if (up.start) begin
            in_busy   <= 1'b1;
            in_cnt    <= CW'(1);
            in_mode_r <= up.mode;
            in_tag_r  <= up.tag;
         end else if (in_busy) begin
            if (in_cnt == LAST) begin
               in_busy <= 1'b0;
               in_cnt  <= '0;
            end else begin
               in_cnt <= in_cnt + CW'(1);
            end
         end
      end
   end

   // Output shifts in zeros, so the digit lines return to 0 once a word drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_busy   <= 1'b0;
         out_cnt    <= '0;
         x_osr      <= '0;
         y_osr      <= '0;
         a_osr      <= '0;
         out_mode_r <= 1'b0;
         out_tag_r  <= '0;
      end else if (w_last) begin
         out_busy   <= 1'b1;
         out_cnt    <= '0;
         x_osr      <= x_res;
         y_osr      <= y_res;
         a_osr      <= a_res;
         out_mode_r <= in_mode_r;
         out_tag_r  <= in_tag_r;
      end else if (out_busy) begin
         x_osr <= x_osr >> DGW;
         y_osr <= y_osr >> DGW;
         a_osr <= a_osr >> DGW;
         if (out_cnt == LAST) begin
            out_busy   <= 1'b0;
            out_cnt    <= '0;
            out_mode_r <= 1'b0;
            out_tag_r  <= '0;
         end else begin
            out_cnt <= out_cnt + CW'(1);
         end
      end
   end

   assign dn.start = out_busy && (out_cnt == '0);
   assign dn.vld   = out_busy;
   assign dn.mode  = out_mode_r;
   assign dn.tag   = out_tag_r;
   assign dn.x     = x_osr[DGW-1:0];
   assign dn.y     = y_osr[DGW-1:0];
   assign dn.a     = a_osr[DGW-1:0];
endmodule

// File: tb/tb_cordic_stage_serial.sv
// tb/tb_cordic_stage_serial.sv - directed-vector bench for cordic_stage_serial (DW=12, DGW=2, STAGE=1)
module tb_cordic_stage_serial;
   localparam int DW   = 12;
   localparam int DGW  = 2;
   localparam int NDIG = DW / DGW;

   typedef struct {
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic [DW-1:0] a;
      logic          mode;
      logic          tag;
      int            cyc;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic protocol_err;
   int   cyc = 0;

   cordic_stage_serial_if #(.DGW(DGW), .TW(1)) up_if ();
   cordic_stage_serial_if #(.DGW(DGW), .TW(1)) dn_if ();

   cordic_stage_serial #(.DW(DW), .DGW(DGW), .STAGE(1), .ATAN(301), .TW(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .up           (up_if.slave),
      .dn           (dn_if.master),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_miss = 0;
   res_t res_q[$];
   int mon_dig = -1;
   res_t cur;
   int vld_run = 0;
   int vld_max = 0;
   int vld_cnt = 0;
   int perr_cnt = 0;
   int last_start = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Rebuilds output words from the digit stream; a start mid-word restarts collection.
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_dig = -1;
         vld_run = 0;
      end else begin
         if (protocol_err) perr_cnt++;
         if (dn_if.vld) begin
            vld_cnt++;
            vld_run++;
            if (vld_run > vld_max) vld_max = vld_run;
            if (dn_if.start) begin
               mon_dig  = 0;
               cur.cyc  = cyc;
               cur.mode = dn_if.mode;
               cur.tag  = dn_if.tag[0];
            end
            if (mon_dig >= 0) begin
               cur.x[mon_dig*DGW +: DGW] = dn_if.x;
               cur.y[mon_dig*DGW +: DGW] = dn_if.y;
               cur.a[mon_dig*DGW +: DGW] = dn_if.a;
               if (mon_dig == NDIG - 1) begin
                  res_q.push_back(cur);
                  mon_dig = -1;
               end else begin
                  mon_dig++;
               end
            end
         end else begin
            vld_run = 0;
         end
      end
   end

   task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] a,
                       input logic m, input logic t, input int ndig);
      for (int k = 0; k < ndig; k++) begin
         up_if.start = (k == 0);
         if (k == 0) begin
            up_if.mode = m;
            up_if.tag  = t;
            last_start = cyc;
         end
         up_if.x = x[k*DGW +: DGW];
         up_if.y = y[k*DGW +: DGW];
         up_if.a = a[k*DGW +: DGW];
         @(posedge clk);
         #1;
      end
      up_if.start = 1'b0;
      up_if.x = '0;
      up_if.y = '0;
      up_if.a = '0;
   endtask

   task automatic wait_res(input int n);
      int b = 0;
      while (res_q.size() < n && b < 40) begin
         @(negedge clk);
         b++;
      end
      chk("wait_results", res_q.size(), n);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic chk_res(input string tag, input res_t r, input logic [DW-1:0] x,
                          input logic [DW-1:0] y, input logic [DW-1:0] a, input logic m, input int st);
      chk({tag, "_x"}, r.x, x);
      chk({tag, "_y"}, r.y, y);
      chk({tag, "_a"}, r.a, a);
      chk({tag, "_mode"}, r.mode, m);
      chk({tag, "_lat"}, r.cyc - st, NDIG);
   endtask

   initial begin
      res_t r;
      int s0, s1, s2;
      up_if.start = 1'b0;
      up_if.vld   = 1'b0;
      up_if.mode  = 1'b0;
      up_if.tag   = 1'b0;
      up_if.x = '0;
      up_if.y = '0;
      up_if.a = '0;

      idle(3);
      chk("rst_outs", {dn_if.vld, dn_if.start, dn_if.mode, dn_if.tag, dn_if.x, dn_if.y, dn_if.a, protocol_err}, '0);
      rst_n = 1'b1;
      idle(2);
      chk("idle_outs", {dn_if.vld, dn_if.start, dn_if.x, dn_if.y, dn_if.a, protocol_err}, '0);

      // 1: rotation 1000,0,100
      send(12'h3E8, 12'h000, 12'h064, 1'b0, 1'b0, NDIG);
      s0 = last_start;
      wait_res(1);
      r = res_q.pop_front();
      chk_res("rot", r, 12'h3E8, 12'h1F4, 12'hF37, 1'b0, s0);
      idle(4);

      // 2: vectoring 800,-400,0 with tag
      send(12'h320, 12'hE70, 12'h000, 1'b1, 1'b1, NDIG);
      s0 = last_start;
      wait_res(1);
      r = res_q.pop_front();
      chk_res("vec", r, 12'h3E8, 12'h000, 12'hED3, 1'b1, s0);
      chk("vec_tag", r.tag, 1'b1);
      idle(4);

      // 3: X overflow 2000,-2000,0
      send(12'h7D0, 12'h830, 12'h000, 1'b0, 1'b0, NDIG);
      s0 = last_start;
      wait_res(1);
      r = res_q.pop_front();
`ifdef CORDIC_SAT_EN
      chk_res("ovf", r, 12'h7FF, 12'hC18, 12'hED3, 1'b0, s0);
`else
      chk_res("ovf", r, 12'hBB8, 12'hC18, 12'hED3, 1'b0, s0);
`endif
      idle(4);

      // 4: three back-to-back words
      vld_max = 0;
      perr_cnt = 0;
      send(12'h3E8, 12'h000, 12'hF9C, 1'b0, 1'b0, NDIG);
      s0 = last_start;
      send(12'h320, 12'h190, 12'h000, 1'b1, 1'b1, NDIG);
      s1 = last_start;
      send(12'h000, 12'h3E8, 12'h032, 1'b0, 1'b0, NDIG);
      s2 = last_start;
      wait_res(3);
      idle(3);
      chk("b2b_vld_run", vld_max, 3 * NDIG);
      chk("b2b_perr", perr_cnt, 0);
      r = res_q.pop_front();
      chk_res("b2b0", r, 12'h3E8, 12'hE0C, 12'h0C9, 1'b0, s0);
      r = res_q.pop_front();
      chk_res("b2b1", r, 12'h3E8, 12'h000, 12'h12D, 1'b1, s1);
      r = res_q.pop_front();
      chk_res("b2b2", r, 12'hE0C, 12'h3E8, 12'hF05, 1'b0, s2);
      idle(4);

      // 5: word A aborted at digit 3 by word B
      perr_cnt = 0;
      res_q.delete();
      send(12'h07B, 12'h111, 12'h222, 1'b1, 1'b1, 3);
      send(12'h3E8, 12'h000, 12'h064, 1'b0, 1'b0, NDIG);
      s0 = last_start;
      wait_res(1);
      idle(10);
      chk("abort_perr", perr_cnt, 1);
      chk("abort_count", res_q.size(), 1);
      r = res_q.pop_front();
      chk_res("abort_b", r, 12'h3E8, 12'h1F4, 12'hF37, 1'b0, s0);
      idle(4);

      // 6: reset during output digit 2
      res_q.delete();
      send(12'h3E8, 12'h000, 12'h064, 1'b0, 1'b0, NDIG);
      idle(2);
      chk("rst_pre", {dn_if.vld, dn_if.x}, {1'b1, 2'd2});
      rst_n = 1'b0;
      #1;
      chk("rst_async", {dn_if.vld, dn_if.start, dn_if.mode, dn_if.tag, dn_if.x, dn_if.y, dn_if.a, protocol_err}, '0);
      idle(3);
      rst_n = 1'b1;
      res_q.delete();
      vld_cnt = 0;
      idle(20);
      chk("rst_no_stale_vld", vld_cnt, 0);
      chk("rst_no_stale_res", res_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
